// File: rtl/aes_128_inv_iter.sv
// Iterative AES-128 inverse cipher. The key is expanded forward to round key
// 10, then one inverse round runs per clock while round keys are derived
// backwards. Optional round-key-10 cache: define AES_DEC_KEY_CACHE_EN.

// Forward S-box lookup
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    assign y = SBOX[a];
endmodule

// Inverse S-box lookup
module aes_inv_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    localparam logic [0:255][7:0] ISBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };
    assign y = ISBOX[a];
endmodule

module aes_128_inv_iter (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out,
    output logic         busy
);
    typedef enum logic [1:0] {IDLE, KEYEXP, ROUND, DONE} fsm_e;

    fsm_e         fsm_q, fsm_d;
    logic [127:0] ct_q, ct_d, s_q, s_d, rk_q, rk_d, out_q, out_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         in_ready_q, in_ready_d, out_valid_q, out_valid_d, busy_q, busy_d;
`ifdef AES_DEC_KEY_CACHE_EN
    logic [127:0] key_q, key_d, cache_key_q, cache_key_d, cache_rk_q, cache_rk_d;
    logic         cache_valid_q, cache_valid_d;
`endif

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rcon_prev(input logic [7:0] r);
        if (r == 8'h1b)      return 8'h80;
        else if (r == 8'h01) return 8'h01;
        else                 return {1'b0, r[7:1]};
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a [4];
        logic [7:0] m9 [4];
        logic [7:0] m11 [4];
        logic [7:0] m13 [4];
        logic [7:0] m14 [4];
        logic [7:0] x2, x4, x8;
        logic [31:0] r;
        for (int unsigned j = 0; j < 4; j++) begin
            a[j]   = c[31-8*j -: 8];
            x2     = xt(a[j]);
            x4     = xt(x2);
            x8     = xt(x4);
            m9[j]  = x8 ^ a[j];
            m11[j] = x8 ^ x2 ^ a[j];
            m13[j] = x8 ^ x4 ^ a[j];
            m14[j] = x8 ^ x4 ^ x2;
        end
        r = '0;
        for (int unsigned j = 0; j < 4; j++)
            r[31-8*j -: 8] = m14[j] ^ m11[(j+1)%4] ^ m13[(j+2)%4] ^ m9[(j+3)%4];
        return r;
    endfunction

    // One shared SubWord: w3 during forward expansion, w3^w2 during the inverse schedule
    logic [31:0]  sw_in, sw_out, t_fwd, f0, f1, f2, f3, i0, i1, i2, i3;
    logic [127:0] rk_fwd, rk_inv, isb, ark, imc;

    assign i3     = rk_q[31:0] ^ rk_q[63:32];
    assign i2     = rk_q[63:32] ^ rk_q[95:64];
    assign i1     = rk_q[95:64] ^ rk_q[127:96];
    assign sw_in  = (fsm_q == KEYEXP) ? rk_q[31:0] : i3;

    for (genvar b = 0; b < 4; b++) begin : g_sw
        // RotWord folded into the byte selection
        aes_sbox u_sbox (.a(sw_in[31-8*((b+1)%4) -: 8]), .y(sw_out[31-8*b -: 8]));
    end

    assign t_fwd  = sw_out ^ {rcon_q, 24'h000000};
    assign f0     = rk_q[127:96] ^ t_fwd;
    assign f1     = rk_q[95:64] ^ f0;
    assign f2     = rk_q[63:32] ^ f1;
    assign f3     = rk_q[31:0] ^ f2;
    assign rk_fwd = {f0, f1, f2, f3};
    assign i0     = rk_q[127:96] ^ sw_out ^ {rcon_q, 24'h000000};
    assign rk_inv = {i0, i1, i2, i3};

    // InvShiftRows folded into which state byte feeds each inverse S-box
    for (genvar i = 0; i < 16; i++) begin : g_isb
        localparam int unsigned C   = i / 4;
        localparam int unsigned R   = i % 4;
        localparam int unsigned SRC = ((C + 4 - R) % 4) * 4 + R;
        aes_inv_sbox u_isb (.a(s_q[127-8*SRC -: 8]), .y(isb[127-8*i -: 8]));
    end

    assign ark = isb ^ rk_inv;
    assign imc = {inv_mix_col(ark[127:96]), inv_mix_col(ark[95:64]),
                  inv_mix_col(ark[63:32]), inv_mix_col(ark[31:0])};

    // Next-state and registered-output logic for the whole core
    always_comb begin
        fsm_d       = fsm_q;
        ct_d        = ct_q;
        s_d         = s_q;
        rk_d        = rk_q;
        rcon_d      = rcon_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_d       = out_q;
        busy_d      = busy_q;
`ifdef AES_DEC_KEY_CACHE_EN
        key_d         = key_q;
        cache_key_d   = cache_key_q;
        cache_rk_d    = cache_rk_q;
        cache_valid_d = cache_valid_q;
`endif
        unique case (fsm_q)
            IDLE: begin
                if (in_valid) begin
                    ct_d       = state;
                    rk_d       = key;
                    rcon_d     = 8'h01;
                    cnt_d      = 4'd1;
                    fsm_d      = KEYEXP;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
`ifdef AES_DEC_KEY_CACHE_EN
                    key_d = key;
                    if (cache_valid_q && (key == cache_key_q)) begin
                        s_d    = state ^ cache_rk_q;
                        rk_d   = cache_rk_q;
                        rcon_d = 8'h36;
                        cnt_d  = 4'd9;
                        fsm_d  = ROUND;
                    end
`endif
                end
            end
            KEYEXP: begin
                rk_d = rk_fwd;
                if (cnt_q == 4'd10) begin
                    // rcon stays 0x36: the first inverse step reuses it
                    s_d   = ct_q ^ rk_fwd;
                    cnt_d = 4'd9;
                    fsm_d = ROUND;
`ifdef AES_DEC_KEY_CACHE_EN
                    cache_key_d   = key_q;
                    cache_rk_d    = rk_fwd;
                    cache_valid_d = 1'b1;
`endif
                end else begin
                    rcon_d = xt(rcon_q);
                    cnt_d  = cnt_q + 4'd1;
                end
            end
            ROUND: begin
                rk_d   = rk_inv;
                rcon_d = rcon_prev(rcon_q);
                if (cnt_q == 4'd0) begin
                    s_d    = ark;
                    fsm_d  = DONE;
                    busy_d = 1'b0;
                end else begin
                    s_d   = imc;
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    out_d       = s_q;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    fsm_d       = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    // State registers, asynchronously cleared
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= IDLE;
            ct_q        <= '0;
            s_q         <= '0;
            rk_q        <= '0;
            rcon_q      <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            busy_q      <= 1'b0;
`ifdef AES_DEC_KEY_CACHE_EN
            key_q         <= '0;
            cache_key_q   <= '0;
            cache_rk_q    <= '0;
            cache_valid_q <= 1'b0;
`endif
        end else begin
            fsm_q       <= fsm_d;
            ct_q        <= ct_d;
            s_q         <= s_d;
            rk_q        <= rk_d;
            rcon_q      <= rcon_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            busy_q      <= busy_d;
`ifdef AES_DEC_KEY_CACHE_EN
            key_q         <= key_d;
            cache_key_q   <= cache_key_d;
            cache_rk_q    <= cache_rk_d;
            cache_valid_q <= cache_valid_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_aes_128_inv_iter.sv
// Directed bench for aes_128_inv_iter with an expected-plaintext scoreboard.
// Hit latency follows AES_DEC_KEY_CACHE_EN when it is defined.
module tb_aes_128_inv_iter;
    logic         clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic         in_ready, out_valid, busy;
    logic [127:0] state_i = '0, key_i = '0, out_o;

    always #5 clk = ~clk;

    aes_128_inv_iter dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .state(state_i), .key(key_i), .out_valid(out_valid), .out_ready(out_ready),
        .out(out_o), .busy(busy)
    );

    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
`ifdef AES_DEC_KEY_CACHE_EN
    localparam int HIT_LAT = 11;
`else
    localparam int HIT_LAT = 21;
`endif

    int n_checks = 0, n_fails = 0, cyc = 0;
    int acc_cyc = 0, busy_cnt = 0;
    logic [127:0] sb_q [$];

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input string tag, input logic [127:0] ct, input logic [127:0] k,
                        input logic [127:0] pt);
        int guard = 0;
        state_i  = ct;
        key_i    = k;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && guard < 50) begin
            tick();
            guard++;
        end
        check({tag, "_in_ready"}, 128'(in_ready), 128'd1);
        sb_q.push_back(pt);
        tick();
        acc_cyc  = cyc;
        in_valid = 1'b0;
        state_i  = ~ct;
        key_i    = ~k;
        busy_cnt = (busy === 1'b1) ? 1 : 0;
    endtask

    task automatic wait_out(input string tag, input int lat_exp);
        int guard = 0;
        while (out_valid !== 1'b1 && guard < 60) begin
            tick();
            guard++;
            if (out_valid !== 1'b1 && busy === 1'b1) busy_cnt++;
        end
        check({tag, "_latency"}, 128'(cyc - acc_cyc), 128'(lat_exp));
        check({tag, "_busy_cycles"}, 128'(busy_cnt), 128'(lat_exp - 1));
    endtask

    task automatic recv(input string tag);
        logic [127:0] exp;
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : 'x;
        check({tag, "_out"}, out_o, exp);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, 128'(out_valid), 128'd0);
        check({tag, "_ready_back"}, 128'(in_ready), 128'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed no end of test, required end before time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int hs, a2, lat1, guard, bad;
        // reset state
        tick();
        tick();
        check("rst_in_ready", 128'(in_ready), 128'd1);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_out", out_o, 128'd0);
        rst_n = 1'b1;
        tick();

        // FIPS-197 appendix B and C.1
        send("b", CT_B, KEY_B, PT_B);
        wait_out("b", 21);
        recv("b");
        send("c1", CT_C, KEY_C, PT_C);
        wait_out("c1", 21);
        recv("c1");

        // backpressure with an ignored in_valid pulse
        send("bp", CT_B, KEY_B, PT_B);
        wait_out("bp", 21);
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_valid", 128'(out_valid), 128'd1);
            check("bp_hold_out", out_o, PT_B);
            check("bp_hold_in_ready", 128'(in_ready), 128'd0);
            if (i == 1) begin
                state_i  = CT_C;
                key_i    = KEY_C;
                in_valid = 1'b1;
            end
            if (i == 3) in_valid = 1'b0;
            tick();
        end
        recv("bp");
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) bad++;
        end
        check("bp_pulse_ignored", 128'(bad), 128'd0);
        check("bp_sb_empty", 128'(sb_q.size()), 128'd0);

        // reset during ROUND abandons the block
        send("rst", CT_C, KEY_C, PT_C);
        repeat (15) tick();
        rst_n = 1'b0;
        #1;
        check("rstmid_out_valid", 128'(out_valid), 128'd0);
        check("rstmid_in_ready", 128'(in_ready), 128'd1);
        check("rstmid_busy", 128'(busy), 128'd0);
        check("rstmid_out", out_o, 128'd0);
        sb_q = {};
        tick();
        rst_n = 1'b1;
        tick();
        send("rstc1", CT_C, KEY_C, PT_C);
        wait_out("rstc1", 21);
        recv("rstc1");

        // back-to-back with in_valid held and out_ready high
        state_i   = CT_B;
        key_i     = KEY_B;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        check("b2b_in_ready", 128'(in_ready), 128'd1);
        sb_q.push_back(PT_B);
        tick();
        acc_cyc = cyc;
        state_i = CT_C;
        key_i   = KEY_C;
        hs = -1;
        a2 = -1;
        lat1 = -1;
        guard = 0;
        while (a2 < 0 && guard < 80) begin
            if (out_valid === 1'b1) begin
                check("b2b_out1", out_o, (sb_q.size() > 0) ? sb_q.pop_front() : 'x);
                lat1 = cyc - acc_cyc;
                hs = cyc + 1;
            end else if (hs >= 0 && in_ready === 1'b1) begin
                sb_q.push_back(PT_C);
                a2 = cyc + 1;
            end
            tick();
            guard++;
        end
        in_valid = 1'b0;
        check("b2b_lat1", 128'(lat1), 128'd21);
        check("b2b_accept_gap", 128'(a2 - hs), 128'd1);
        acc_cyc  = cyc;
        busy_cnt = (busy === 1'b1) ? 1 : 0;
        wait_out("b2b2", 21);
        recv("b2b2");

        // same key twice, then a new key
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        send("kc1", CT_C, KEY_C, PT_C);
        wait_out("kc1", 21);
        recv("kc1");
        send("kc2", CT_C, KEY_C, PT_C);
        wait_out("kc2", HIT_LAT);
        recv("kc2");
        send("kb", CT_B, KEY_B, PT_B);
        wait_out("kb", 21);
        recv("kb");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
